// File: rtl/shift_seq_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_seq_unit_pkg
// Purpose  : Shared opcodes, FSM states and effective-count helper for the
//            sequential shift/rotate unit.
// Revision : 1.0 - initial release
// ============================================================================
package shift_seq_unit_pkg;

  localparam int DATA_W_DEF = 8;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Shifts saturate at a full register width; rotates wrap modulo 8.
  function automatic logic [3:0] eff_count(input logic [1:0] op, input logic [3:0] amt);
    if (op == OP_ROR) begin
      return {1'b0, amt[2:0]};
    end else if (amt > 4'd8) begin
      return 4'd8;
    end else begin
      return amt;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_seq_unit_step.sv
`default_nettype none
// ============================================================================
// Module   : shift_step
// Purpose  : Combinational one-position shift/rotate of a DATA_W-bit value.
// Revision : 1.0 - initial release
// ============================================================================
module shift_step
  import shift_seq_unit_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_dout
);

  // Single-bit move in the direction selected by the opcode.
  always_comb begin
    o_dout = i_din;
    case (i_op)
      OP_SLL:  o_dout = {i_din[DATA_W-2:0], 1'b0};
      OP_SRL:  o_dout = {1'b0, i_din[DATA_W-1:1]};
      OP_SRA:  o_dout = {i_din[DATA_W-1], i_din[DATA_W-1:1]};
      default: o_dout = {i_din[0], i_din[DATA_W-1:1]};
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/shift_seq_unit.sv
`default_nettype none
// ============================================================================
// Module   : shift_seq_unit
// Purpose  : Sequential shift/rotate unit, one bit position per clock, with a
//            START/BUSY/DONE handshake and a registered RESULT.
// Options  : SHIFT_SEQ_EARLY_EXIT_EN - finish early once further shifting
//            cannot change the value (sll/srl at 0x00, sra at 0x00/0xFF).
// Revision : 1.0 - initial release
// ============================================================================
module shift_seq_unit
  import shift_seq_unit_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic [DATA_W-1:0] DATA1,
  input  logic [DATA_W-1:0] DATA2,
  output logic              BUSY,
  output logic              DONE,
  output logic [DATA_W-1:0] RESULT
);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] step_w;
  logic [3:0]        eff_w;
  logic              early_w;
  logic              unused_data2_w;

  // DATA2[5:4] carries no meaning for this unit.
  assign unused_data2_w = ^DATA2[5:4];

  assign eff_w = eff_count(DATA2[7:6], DATA2[3:0]);

  shift_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .i_op   (op_q),
    .i_din  (sr_q),
    .o_dout (step_w)
  );

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
  // Value is a fixed point of the shift, so the remaining steps are no-ops.
  always_comb begin
    early_w = 1'b0;
    if ((op_q == OP_SLL) || (op_q == OP_SRL)) begin
      early_w = (sr_q == '0);
    end else if (op_q == OP_SRA) begin
      early_w = (sr_q == '0) || (sr_q == '1);
    end
  end
`else
  assign early_w = 1'b0;
`endif

  // Next-state, datapath and result selection.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          sr_d  = DATA1;
          op_d  = DATA2[7:6];
          cnt_d = CNT_W'(eff_w);
          if (eff_w == 4'd0) begin
            state_d  = ST_DONE;
            result_d = DATA1;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        sr_d  = step_w;
        cnt_d = cnt_q - 1'b1;
        // step_w equals sr_q on an early exit, so the result is unchanged.
        if ((cnt_q == CNT_W'(1)) || early_w) begin
          state_d  = ST_DONE;
          cnt_d    = '0;
          result_d = step_w;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_d = (state_d != ST_IDLE);
  assign done_d = (state_d == ST_DONE);

  // State, datapath and registered outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_SLL;
      cnt_q    <= '0;
      sr_q     <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign RESULT = result_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_seq_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_seq_unit
// Purpose  : Scoreboard bench for shift_seq_unit against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_seq_unit;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       START = 1'b0;
  logic [7:0] DATA1 = 8'h00;
  logic [7:0] DATA2 = 8'h00;
  logic       BUSY;
  logic       DONE;
  logic [7:0] RESULT;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] res;
    int         t0;
    int         eff;
  } exp_t;

  exp_t       q[$];
  logic [7:0] last_res = 8'h00;
  bit         prev_done = 1'b0;

  shift_seq_unit #(
    .DATA_W (8),
    .CNT_W  (4)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .START   (START),
    .DATA1   (DATA1),
    .DATA2   (DATA2),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .RESULT  (RESULT)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc = cyc + 1;

  function automatic int eff_of(input logic [7:0] d2);
    int a;
    a = int'(d2[3:0]);
    if (d2[7:6] == 2'b11) return a % 8;
    return (a > 8) ? 8 : a;
  endfunction

  function automatic logic [7:0] model(input logic [7:0] d1, input logic [7:0] d2);
    int v;
    int k;
    int s;
    v = int'(d1);
    k = eff_of(d2);
    case (d2[7:6])
      2'b00:   return 8'((v << k) & 255);
      2'b01:   return 8'(v >> k);
      2'b10: begin
        s = (v >= 128) ? v - 256 : v;
        return 8'(s >>> k);
      end
      default: return 8'(((v >> k) | (v << (8 - k))) & 255);
    endcase
  endfunction

  // Monitor: pops the scoreboard on every DONE and checks value and timing.
  always @(negedge CLK) begin
    exp_t e;
    int   lat;
    bit   lat_ok;
    if (!RESET_N) begin
      last_res  = 8'h00;
      prev_done = 1'b0;
    end else begin
      if (prev_done) begin
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0) begin
          errors++;
          $display("FAIL done_then_idle busy=%0b done=%0b required busy=0 done=0", BUSY, DONE);
        end
      end
      if (DONE === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done result=%02h required no DONE", RESULT);
        end else begin
          e = q.pop_front();
          if (RESULT !== e.res) begin
            errors++;
            $display("FAIL result got=%02h exp=%02h", RESULT, e.res);
          end
          lat = cyc - e.t0;
`ifdef SHIFT_SEQ_EARLY_EXIT_EN
          lat_ok = (lat <= e.eff);
`else
          lat_ok = (lat == e.eff);
`endif
          checks++;
          if (!lat_ok) begin
            errors++;
            $display("FAIL done_latency got=%0d exp=%0d", lat, e.eff);
          end
          checks++;
          if (BUSY !== 1'b1) begin
            errors++;
            $display("FAIL busy_at_done got=%0b exp=1", BUSY);
          end
          last_res = e.res;
        end
      end else begin
        checks++;
        if (RESULT !== last_res) begin
          errors++;
          $display("FAIL result_hold got=%02h exp=%02h", RESULT, last_res);
        end
      end
      prev_done = (DONE === 1'b1);
    end
  end

  // Issue one operation; optionally fire an ignored START at T0+1.
  task automatic issue(input logic [7:0] d1, input logic [7:0] d2, input bit garbage);
    exp_t e;
    int   n;
    @(negedge CLK);
    START = 1'b1;
    DATA1 = d1;
    DATA2 = d2;
    @(posedge CLK);
    #1;
    e.res = model(d1, d2);
    e.eff = eff_of(d2);
    e.t0  = cyc;
    q.push_back(e);
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start got=%0b exp=1", BUSY);
    end
    START = garbage;
    DATA1 = 8'($urandom);
    DATA2 = 8'($urandom);
    @(posedge CLK);
    #1;
    START = 1'b0;
    n = 0;
    while (BUSY === 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL busy_timeout busy=%0b required 0 within 20 cycles", BUSY);
    end
  endtask

  initial begin
    logic [7:0] d1;
    #12;
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || RESULT !== 8'h00) begin
      errors++;
      $display("FAIL reset_state busy=%0b done=%0b result=%02h required 0/0/00", BUSY, DONE, RESULT);
    end
    @(negedge CLK);
    RESET_N = 1'b1;

    issue(8'h81, 8'h03, 1'b0);
    issue(8'h80, 8'h42, 1'b0);
    issue(8'h0F, 8'hCB, 1'b0);
    issue(8'h90, 8'h8A, 1'b0);
    issue(8'h5A, 8'h40, 1'b0);
    issue(8'h81, 8'h03, 1'b1);
    issue(8'h5A, 8'h40, 1'b1);
    issue(8'h00, 8'h05, 1'b0);
    issue(8'hFF, 8'h8F, 1'b0);

    for (int i = 0; i < 40; i++) begin
      d1 = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      issue(d1, 8'($urandom), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of an sll by 7.
    @(negedge CLK);
    START = 1'b1;
    DATA1 = 8'hFF;
    DATA2 = 8'h07;
    @(posedge CLK);
    #1;
    START = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESET_N = 1'b0;
    #1;
    checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || RESULT !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset busy=%0b done=%0b result=%02h required 0/0/00", BUSY, DONE, RESULT);
    end
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (12) @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0 || RESULT !== 8'h00) begin
      errors++;
      $display("FAIL post_reset_idle busy=%0b result=%02h required 0/00", BUSY, RESULT);
    end
    issue(8'hFF, 8'h07, 1'b0);

    repeat (4) @(negedge CLK);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
